usb_unstuffer_param: RTL



---
 rtl/usb_unstuffer_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/usb_unstuffer_param.sv
// usb_unstuffer_param: USB receive-path bit unstuffer with configurable run
// length, stuff polarity and leading skip window. Drops the stuff bit that
// follows RUN_LEN consecutive STUFF_VAL bits, flags stuff violations, counts
// removed bits per packet and offers a runtime bypass. All outputs are
// registered with exactly one cycle of latency.
module usb_unstuffer_param #(
  parameter int RUN_LEN   = 6,
  parameter bit STUFF_VAL = 1'b1,
  parameter int SKIP_BITS = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bstr_in,
  input  logic             bstr_in_avail,
  input  logic             in_done,
  output logic             bstr_out,
  output logic             bstr_out_avail,
  output logic             out_done,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuffed_cnt
);

  localparam int DEPTH_W = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;
  localparam int RUN_W   = $clog2(RUN_LEN + 1);

  localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // IDLE: no packet; COUNT: counting runs; STUFF: next valid bit is a stuff slot
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_STUFF = 2'd2;

  logic [1:0]         r_state;
  logic [DEPTH_W-1:0] r_depth;
  logic [RUN_W-1:0]   r_run;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out;
  logic               r_out_avail;
  logic               r_out_done;
  logic               r_err;

  logic [1:0]         w_state_nx;
  logic [DEPTH_W-1:0] w_depth_nx;
  logic [RUN_W-1:0]   w_run_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_drop;
  logic               w_err;
  logic               w_in_skip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The skip window only exists when SKIP_BITS is non-zero; depth saturates
  // at SKIP_BITS, so inequality is enough to detect "still inside the window".
  generate
    if (SKIP_BITS == 0) begin : g_no_skip
      assign w_in_skip = 1'b0;
    end else begin : g_skip
      assign w_in_skip = (r_depth != DEPTH_W'(SKIP_BITS));
    end
  endgenerate

  // Next-state decode for the current input bit, then end-of-packet clearing
  always_comb begin
    w_state_nx = r_state;
    w_depth_nx = r_depth;
    w_run_nx   = r_run;
    w_cnt_nx   = r_cnt;
    w_drop     = 1'b0;
    w_err      = 1'b0;
    if (bstr_in_avail) begin
      // A new packet restarts the removed-bit count, except in bypass where
      // the count is frozen.
      if (r_state == S_IDLE && en) begin
        w_cnt_nx = '0;
      end
      if (!en) begin
        w_state_nx = S_COUNT;
        w_depth_nx = '0;
        w_run_nx   = '0;
      end else if (r_state == S_STUFF) begin
        w_drop     = 1'b1;
        w_err      = (bstr_in == STUFF_VAL);
        w_cnt_nx   = sat_inc(w_cnt_nx);
        w_state_nx = S_COUNT;
        w_run_nx   = '0;
      end else begin
        w_state_nx = S_COUNT;
        if (w_in_skip) begin
          w_depth_nx = r_depth + 1'b1;
        end else if (bstr_in == STUFF_VAL) begin
          if (r_run == RUN_TOP) begin
            w_state_nx = S_STUFF;
            w_run_nx   = '0;
          end else begin
            w_run_nx = r_run + 1'b1;
          end
        end else begin
          w_run_nx = '0;
        end
      end
    end
    // End of packet wins over everything above; a pending stuff slot is
    // simply forgotten.
    if (in_done) begin
      w_state_nx = S_IDLE;
      w_depth_nx = '0;
      w_run_nx   = '0;
    end
  end

  // State and registered outputs; bstr_out only follows forwarded bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_run       <= '0;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_out_avail <= 1'b0;
      r_out_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_depth     <= w_depth_nx;
      r_run       <= w_run_nx;
      r_cnt       <= w_cnt_nx;
      r_out_avail <= bstr_in_avail && !w_drop;
      r_out_done  <= in_done;
      r_err       <= w_err;
      if (bstr_in_avail && !w_drop) begin
        r_out <= bstr_in;
      end
    end
  end

  assign bstr_out       = r_out;
  assign bstr_out_avail = r_out_avail;
  assign out_done       = r_out_done;
  assign stuff_err      = r_err;
  assign stuffed_cnt    = r_cnt;

endmodule
